// File: rtl/rv32_wb_arbiter_if.sv
// Writeback arbiter bus bundle.
// Carries the two writeback requesters (A = ALU, B = load/CSR unit), the
// register-file write port, the issue-stage allocate port, the two hazard
// queries and the sticky WAW error flag.
//   slave  : the arbiter side (rv32_wb_arbiter)
//   master : the surrounding pipeline / testbench side
interface rv32_wb_arbiter_if;
    logic        a_valid_in;
    logic        a_ready_out;
    logic [4:0]  a_rd_addr_in;
    logic [31:0] a_data_in;
    logic        b_valid_in;
    logic        b_ready_out;
    logic [4:0]  b_rd_addr_in;
    logic [31:0] b_data_in;
    logic        rf_wr_en_out;
    logic [4:0]  rf_rd_addr_out;
    logic [31:0] rf_rd_out;
    logic        alloc_en_in;
    logic [4:0]  alloc_addr_in;
    logic [4:0]  rs_1_addr_in;
    logic [4:0]  rs_2_addr_in;
    logic        rs_1_busy_out;
    logic        rs_2_busy_out;
    logic        waw_err_out;

    modport slave (
        input  a_valid_in, a_rd_addr_in, a_data_in,
        input  b_valid_in, b_rd_addr_in, b_data_in,
        input  alloc_en_in, alloc_addr_in, rs_1_addr_in, rs_2_addr_in,
        output a_ready_out, b_ready_out,
        output rf_wr_en_out, rf_rd_addr_out, rf_rd_out,
        output rs_1_busy_out, rs_2_busy_out, waw_err_out
    );

    modport master (
        output a_valid_in, a_rd_addr_in, a_data_in,
        output b_valid_in, b_rd_addr_in, b_data_in,
        output alloc_en_in, alloc_addr_in, rs_1_addr_in, rs_2_addr_in,
        input  a_ready_out, b_ready_out,
        input  rf_wr_en_out, rf_rd_addr_out, rf_rd_out,
        input  rs_1_busy_out, rs_2_busy_out, waw_err_out
    );
endinterface

// File: rtl/rv32_wb_arbiter.sv
// Two-port writeback arbiter with register-file pending scoreboard.
// Ports:
//   clk_in    : clock, all state on rising edge
//   reset_in  : asynchronous active-low reset
//   wb        : rv32_wb_arbiter_if.slave (requesters A/B, RF write port,
//               allocate port, rs1/rs2 hazard queries, sticky WAW flag)
// Parameter PRIO_MODE: 0 = round-robin on ties, 1 = A always wins ties.
// The RF write port is registered (one-cycle latency from handshake).
module rv32_wb_arbiter #(
    parameter int PRIO_MODE = 0
) (
    input  logic           clk_in,
    input  logic           reset_in,
    rv32_wb_arbiter_if.slave wb
);

    logic        last_b_q;      // 1: most recent transfer was granted to B
    logic        wr_en_q;
    logic [4:0]  wr_addr_q;
    logic [31:0] wr_data_q;
    logic [31:0] pend_q, pend_d;
    logic        waw_q, waw_d;

    logic        grant_a, grant_b, xfer;
    logic [4:0]  sel_rd;
    logic [31:0] sel_data;

    // Grant: sole valid wins; ties go to A in fixed mode, otherwise to the
    // port that did not win the last transfer. Held low during reset.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (reset_in) begin
            if (wb.a_valid_in && wb.b_valid_in) begin
                if (PRIO_MODE != 0 || last_b_q) grant_a = 1'b1;
                else                            grant_b = 1'b1;
            end else begin
                grant_a = wb.a_valid_in;
                grant_b = wb.b_valid_in;
            end
        end
    end

    assign xfer     = grant_a | grant_b;
    assign sel_rd   = grant_a ? wb.a_rd_addr_in : wb.b_rd_addr_in;
    assign sel_data = grant_a ? wb.a_data_in    : wb.b_data_in;

    // Scoreboard next state: clear on the RF write, then set on alloc so a
    // same-address alloc in the write cycle leaves the bit pending.
    always_comb begin
        pend_d = pend_q;
        if (wr_en_q) pend_d[wr_addr_q] = 1'b0;
        if (wb.alloc_en_in && wb.alloc_addr_in != 5'd0)
            pend_d[wb.alloc_addr_in] = 1'b1;
        pend_d[0] = 1'b0;
    end

    // WAW: re-allocating a pending register that is not retiring this cycle.
    always_comb begin
        waw_d = waw_q;
        if (wb.alloc_en_in && wb.alloc_addr_in != 5'd0 &&
            pend_q[wb.alloc_addr_in] &&
            !(wr_en_q && wr_addr_q == wb.alloc_addr_in))
            waw_d = 1'b1;
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            last_b_q  <= 1'b1;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 5'd0;
            wr_data_q <= 32'd0;
            pend_q    <= 32'd0;
            waw_q     <= 1'b0;
        end else begin
            if (xfer) last_b_q <= grant_b;
            // rd=0 transfers handshake normally but never write.
            wr_en_q <= xfer && (sel_rd != 5'd0);
            if (xfer && sel_rd != 5'd0) begin
                wr_addr_q <= sel_rd;
                wr_data_q <= sel_data;
            end
            pend_q <= pend_d;
            waw_q  <= waw_d;
        end
    end

    assign wb.a_ready_out    = grant_a;
    assign wb.b_ready_out    = grant_b;
    assign wb.rf_wr_en_out   = wr_en_q;
    assign wb.rf_rd_addr_out = wr_addr_q;
    assign wb.rf_rd_out      = wr_data_q;
    assign wb.waw_err_out    = waw_q;

    // The RF forwards same-cycle write data, so a retiring register is free.
    assign wb.rs_1_busy_out = (wb.rs_1_addr_in != 5'd0) && pend_q[wb.rs_1_addr_in] &&
                              !(wr_en_q && wr_addr_q == wb.rs_1_addr_in);
    assign wb.rs_2_busy_out = (wb.rs_2_addr_in != 5'd0) && pend_q[wb.rs_2_addr_in] &&
                              !(wr_en_q && wr_addr_q == wb.rs_2_addr_in);

endmodule

// File: doc/rv32_wb_arbiter.md
RV32_WB_ARBITER -- requirements
Module: rv32_wb_arbiter

Interface
REQ-001 SHALL have parameter: PRIO_MODE, 0, arbitration mode (0 = round-robin, 1 = fixed priority, port A wins).
REQ-002 SHALL have port: clk_in  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: reset_in  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: a_valid_in / b_valid_in  input  1  writeback request from ALU (A) / load-CSR unit (B).
REQ-005 SHALL have ports: a_ready_out / b_ready_out  output  1  grant; transfer occurs when valid and ready are both 1 in the same cycle.
REQ-006 SHALL have ports: a_rd_addr_in / b_rd_addr_in  input  5  destination register.
REQ-007 SHALL have ports: a_data_in / b_data_in  input  32  writeback data.
REQ-008 SHALL have ports: rf_wr_en_out  output  1, rf_rd_addr_out  output  5, rf_rd_out  output  32; these drive the integer register file write port.
REQ-009 SHALL have ports: alloc_en_in  input  1, alloc_addr_in  input  5; issue stage marks rd pending.
REQ-010 SHALL have ports: rs_1_addr_in, rs_2_addr_in  input  5; rs_1_busy_out, rs_2_busy_out  output  1; hazard query.
REQ-011 SHALL have port: waw_err_out  output  1  sticky error flag.

Function
REQ-012 SHALL register the write port: a transfer in cycle N drives rf_wr_en_out=1, rf_rd_addr_out, rf_rd_out in cycle N+1 for exactly one cycle; the latency is fixed at 1.
REQ-013 SHALL deassert rf_wr_en_out in every cycle following a cycle with no transfer; rf_rd_addr_out and rf_rd_out hold their last values.
REQ-014 SHALL compute ready combinationally from the valids and the arbiter state; at most one ready=1 per cycle, and ready is never 1 for a port whose valid is 0.
REQ-015 SHALL grant the sole valid port when only one port is valid.
REQ-016 SHALL, when both ports are valid with PRIO_MODE=0, grant the port not granted by the most recent transfer; the last_grant state updates only on a transfer.
REQ-017 SHALL, when both ports are valid with PRIO_MODE=1, always grant A; B may starve.
REQ-018 SHALL require requesters to hold valid, address and data stable until accepted; the arbiter does not check this.
REQ-019 SHALL complete a transfer with rd=0 normally (ready=1), with rf_wr_en_out=0 in the next cycle and no scoreboard effect.
REQ-020 SHALL keep a 32-bit pending bitmap; bit 0 is always 0.
REQ-021 SHALL set pending[alloc_addr_in] at the clock edge when alloc_en_in=1 and alloc_addr_in!=0.
REQ-022 SHALL clear pending[rf_rd_addr_out] at the clock edge ending a cycle with rf_wr_en_out=1.
REQ-023 SHALL, when an alloc and a clear target the same address in one cycle, leave the bit set (alloc wins).
REQ-024 SHALL ignore a clear on a non-pending bit, with no error.
REQ-025 SHALL drive rs_x_busy_out = pending[rs_x_addr_in] AND NOT (rf_wr_en_out AND rf_rd_addr_out==rs_x_addr_in); it is combinational, since the register file forwards same-cycle write data. The output is 0 for address 0.
REQ-026 SHALL set waw_err_out when alloc_en_in=1 targets an already-pending nonzero address that is not being cleared that cycle; it stays set until reset, and the bit remains set.
REQ-027 SHALL let two same-rd transfers (A and B) both complete in grant order; the first clears pending, and the register file holds the later value.

Reset
REQ-028 SHALL, while reset_in=0, asynchronously force rf_wr_en_out=0, rf_rd_addr_out=0, rf_rd_out=0, pending=0, waw_err_out=0, and last_grant=B (so A wins the first tie).
REQ-029 SHALL hold a_ready_out=b_ready_out=0 while reset_in=0; requests in flight are dropped, with no write after reset release.
REQ-030 SHALL accept requests in the first rising edge after reset_in returns to 1.

Verification
REQ-031 SHALL cover: A only, rd=5, data 0x1234_5678 -> a_ready_out=1 same cycle; next cycle rf_wr_en_out=1, rf_rd_addr_out=5, rf_rd_out=0x12345678; following cycle rf_wr_en_out=0.
REQ-032 SHALL cover: PRIO_MODE=0, A and B both valid for 4 cycles after reset -> grants A,B,A,B; with PRIO_MODE=1 -> A,A,A,A and b_ready_out=0.
REQ-033 SHALL cover: alloc rd=7; query rs_1=7 -> busy=1; B writes rd=7 -> busy=0 in the rf_wr_en_out cycle, and pending[7]=0 after it.
REQ-034 SHALL cover: alloc rd=9 in the same cycle that rf writes rd=9 -> pending[9] stays 1, waw_err_out=0; alloc rd=9 again later -> waw_err_out=1 and stays 1.
REQ-035 SHALL cover: A writes rd=0 -> handshake completes, rf_wr_en_out=0; rs_1_addr_in=0 -> busy=0 always.
REQ-036 SHALL cover: reset_in pulled low between a transfer and its write cycle -> rf_wr_en_out=0 immediately, pending=0, and no write after release.
